multicycle_ctrl_v2: RTL and testbench

//  Next-generation multicycle RV32I control FSM. Drives regfile/IR/PC enables, the memory request and the datapath mux selects.

---
 rtl/multicycle_ctrl_v2_pkg.sv | 63 ++++++
 rtl/multicycle_ctrl_v2_if.sv | 36 +++
 rtl/multicycle_ctrl_v2_mem_wait_timer.sv | 46 ++++
 rtl/multicycle_ctrl_v2.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl_v2.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_v2_pkg.sv
// Shared types for the multicycle RV32I controller: opcodes, FSM states,
// datapath select encodings and trap causes.
package multicycle_ctrl_v2_pkg;

    typedef enum logic [6:0] {
        LOAD     = 7'b0000011,
        MISC_MEM = 7'b0001111,
        OP_IMM   = 7'b0010011,
        AUIPC    = 7'b0010111,
        STORE    = 7'b0100011,
        OP       = 7'b0110011,
        LUI      = 7'b0110111,
        BRANCH   = 7'b1100011,
        JALR     = 7'b1100111,
        JAL      = 7'b1101111,
        SYSTEM   = 7'b1110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        NOT_JUMPING,
        JUMP_I_TYPE,
        JUMP_J_TYPE,
        BRANCH_B_TYPE,
        TRAP_VECTOR
    } jump_type_t;

    typedef enum logic [1:0] {
        FROM_ALU,
        FROM_MEM,
        FROM_PC_PLUS_4,
        FROM_IMM_U
    } regfile_sel_t;

    typedef enum logic [1:0] {
        ILLEGAL,
        ECALL,
        EBREAK,
        BUS_TIMEOUT
    } trap_cause_t;

    // State names carry an ST_ prefix so they do not collide with opcode names.
    typedef enum logic [3:0] {
        ST_RST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_EXEC_U,
        ST_MEM,
        ST_JAL,
        ST_JALR,
        ST_BRANCH,
        ST_TRAP,
        ST_HALT
    } state_t;

    localparam int WAIT_CNT_W = 8;

    function automatic trap_cause_t system_cause(input logic is_ebreak);
        return is_ebreak ? EBREAK : ECALL;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_v2_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// and memory (slave).
interface multicycle_ctrl_v2_if;
    import multicycle_ctrl_v2_pkg::*;

    rv32i_opcode_t opcode;
    logic          is_ebreak;
    logic          take_branch;
    logic          mem_ready;

    logic          regfile_wren;
    logic          ir_wren;
    logic          pc_inc;
    logic          mem_req;
    logic          mem_wren;
    logic          addr_sel_alu;
    logic          alu_a_sel_pc;
    jump_type_t    jumping;
    regfile_sel_t  regfile_sel;
    logic          trap_valid;
    trap_cause_t   trap_cause;
    logic          halted;

    modport master (
        input  opcode, is_ebreak, take_branch, mem_ready,
        output regfile_wren, ir_wren, pc_inc, mem_req, mem_wren, addr_sel_alu,
               alu_a_sel_pc, jumping, regfile_sel, trap_valid, trap_cause, halted
    );

    modport slave (
        output opcode, is_ebreak, take_branch, mem_ready,
        input  regfile_wren, ir_wren, pc_inc, mem_req, mem_wren, addr_sel_alu,
               alu_a_sel_pc, jumping, regfile_sel, trap_valid, trap_cause, halted
    );

endinterface

// File: rtl/multicycle_ctrl_v2_mem_wait_timer.sv
// Memory wait counter shared by FETCH and MEM: produces mem_done for fixed
// latency or ready handshake, and the optional bus timeout.
module multicycle_ctrl_v2_mem_wait_timer
    import multicycle_ctrl_v2_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 0,
    parameter int MEM_LATENCY   = 1,
    parameter int MEM_TIMEOUT   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic mem_ready,
    output logic mem_done,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] LAT_CNT = WAIT_CNT_W'(MEM_LATENCY);
    localparam logic [WAIT_CNT_W-1:0] TO_CNT  = WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

    logic [WAIT_CNT_W-1:0] wait_cnt;

    function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : (wait_cnt == LAT_CNT);
        timeout  = (MEM_HANDSHAKE != 0) && (MEM_TIMEOUT != 0) &&
                   (wait_cnt == TO_CNT) && !mem_ready;
    end

    // Counting stops the moment the access completes or times out, so the
    // next FETCH/MEM always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (busy && !mem_done && !timeout) begin
            wait_cnt <= sat_inc(wait_cnt);
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory, drives
// the datapath enables and selects, and handles traps by vectoring or halting.
module multicycle_ctrl_v2
    import multicycle_ctrl_v2_pkg::*;
#(
    parameter int MEM_HANDSHAKE  = 0,
    parameter int MEM_LATENCY    = 1,
    parameter int MEM_TIMEOUT    = 0,
    parameter int TRAP_VECTOR_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_v2_if.master bus
);

    state_t      state, state_d;
    trap_cause_t cause_q, cause_d;
    logic        busy, mem_done, timeout;

    assign busy = (state == ST_FETCH) || (state == ST_MEM);

    multicycle_ctrl_v2_mem_wait_timer #(
        .MEM_HANDSHAKE (MEM_HANDSHAKE),
        .MEM_LATENCY   (MEM_LATENCY),
        .MEM_TIMEOUT   (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (busy),
        .mem_ready (bus.mem_ready),
        .mem_done  (mem_done),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RST_IDLE;
            cause_q <= ILLEGAL;
        end else begin
            state   <= state_d;
            cause_q <= cause_d;
        end
    end

    // Outputs depend on the current state (plus done/branch qualifiers), so an
    // asynchronous reset drops every strobe immediately.
    always_comb begin
        state_d          = state;
        cause_d          = cause_q;
        bus.regfile_wren = 1'b0;
        bus.ir_wren      = 1'b0;
        bus.pc_inc       = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_wren     = 1'b0;
        bus.addr_sel_alu = 1'b0;
        bus.alu_a_sel_pc = 1'b0;
        bus.jumping      = NOT_JUMPING;
        bus.regfile_sel  = FROM_ALU;
        bus.trap_valid   = 1'b0;
        bus.halted       = 1'b0;

        case (state)
            ST_RST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                bus.mem_req = 1'b1;
                if (mem_done) begin
                    bus.ir_wren = 1'b1;
                    bus.pc_inc  = 1'b1;
                    state_d     = ST_DECODE;
                end else if (timeout) begin
                    cause_d = BUS_TIMEOUT;
                    state_d = ST_TRAP;
                end
            end

            ST_DECODE: begin
                case (bus.opcode)
                    OP:            state_d = ST_EXEC_R;
                    OP_IMM:        state_d = ST_EXEC_I;
                    LUI, AUIPC:    state_d = ST_EXEC_U;
                    LOAD, STORE:   state_d = ST_MEM;
                    JAL:           state_d = ST_JAL;
                    JALR:          state_d = ST_JALR;
                    BRANCH:        state_d = ST_BRANCH;
                    MISC_MEM:      state_d = ST_FETCH;
                    SYSTEM: begin
                        cause_d = system_cause(bus.is_ebreak);
                        state_d = ST_TRAP;
                    end
                    default: begin
                        cause_d = ILLEGAL;
                        state_d = ST_TRAP;
                    end
                endcase
            end

            ST_EXEC_R, ST_EXEC_I: begin
                bus.regfile_wren = 1'b1;
                state_d          = ST_FETCH;
            end

            ST_EXEC_U: begin
                bus.regfile_wren = 1'b1;
                if (bus.opcode == LUI) begin
                    bus.regfile_sel = FROM_IMM_U;
                end else begin
                    bus.alu_a_sel_pc = 1'b1;
                end
                state_d = ST_FETCH;
            end

            ST_MEM: begin
                bus.mem_req      = 1'b1;
                bus.addr_sel_alu = 1'b1;
                if (bus.opcode == STORE) begin
                    bus.mem_wren = 1'b1;
                end else begin
                    bus.regfile_sel  = FROM_MEM;
                    bus.regfile_wren = mem_done;
                end
                if (mem_done) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    cause_d = BUS_TIMEOUT;
                    state_d = ST_TRAP;
                end
            end

            ST_JAL, ST_JALR: begin
                bus.regfile_sel  = FROM_PC_PLUS_4;
                bus.regfile_wren = 1'b1;
                bus.pc_inc       = 1'b1;
                bus.jumping      = (state == ST_JAL) ? JUMP_J_TYPE : JUMP_I_TYPE;
                state_d          = ST_FETCH;
            end

            ST_BRANCH: begin
                if (bus.take_branch) begin
                    bus.jumping = BRANCH_B_TYPE;
                    bus.pc_inc  = 1'b1;
                end
                state_d = ST_FETCH;
            end

            ST_TRAP: begin
                bus.trap_valid = 1'b1;
                if (TRAP_VECTOR_EN != 0) begin
                    bus.jumping = TRAP_VECTOR;
                    bus.pc_inc  = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end

            ST_HALT: bus.halted = 1'b1;

            default: state_d = ST_RST_IDLE;
        endcase
    end

    assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench for multicycle_ctrl_v2 across fixed-latency, handshake/timeout
// and halt-on-trap configurations.
module tb_multicycle_ctrl_v2;
    import multicycle_ctrl_v2_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_v2_if bus_a ();
    multicycle_ctrl_v2_if bus_b ();
    multicycle_ctrl_v2_if bus_c ();

    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(0), .MEM_LATENCY(2), .MEM_TIMEOUT(0), .TRAP_VECTOR_EN(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1), .MEM_LATENCY(1), .MEM_TIMEOUT(5), .TRAP_VECTOR_EN(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1), .MEM_LATENCY(1), .MEM_TIMEOUT(0), .TRAP_VECTOR_EN(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_a.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b exp 0", bus_a.mem_req); end
        n_cmp++; if (bus_a.jumping !== NOT_JUMPING) begin n_fail++; $display("FAIL rst_jumping got %0d exp %0d", bus_a.jumping, NOT_JUMPING); end
        n_cmp++; if (bus_a.regfile_sel !== FROM_ALU) begin n_fail++; $display("FAIL rst_regfile_sel got %0d exp %0d", bus_a.regfile_sel, FROM_ALU); end
        n_cmp++; if (bus_a.trap_cause !== ILLEGAL) begin n_fail++; $display("FAIL rst_trap_cause got %0d exp %0d", bus_a.trap_cause, ILLEGAL); end
        n_cmp++; if (bus_c.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b exp 0", bus_c.halted); end
        do_reset();
    endtask

    // Cycle 1 is the first cycle after reset release (RST_IDLE).
    task automatic test_addi_latency();
        logic [6:1] e_req, e_ir, e_wr;
        e_req = 6'b001110;
        e_ir  = 6'b001000;
        e_wr  = 6'b100000;
        bus_a.opcode = OP_IMM;
        for (int c = 1; c <= 6; c++) begin
            n_cmp++; if (bus_a.mem_req !== e_req[c]) begin n_fail++; $display("FAIL addi_mem_req c%0d got %b exp %b", c, bus_a.mem_req, e_req[c]); end
            n_cmp++; if (bus_a.ir_wren !== e_ir[c]) begin n_fail++; $display("FAIL addi_ir_wren c%0d got %b exp %b", c, bus_a.ir_wren, e_ir[c]); end
            n_cmp++; if (bus_a.pc_inc !== e_ir[c]) begin n_fail++; $display("FAIL addi_pc_inc c%0d got %b exp %b", c, bus_a.pc_inc, e_ir[c]); end
            n_cmp++; if (bus_a.regfile_wren !== e_wr[c]) begin n_fail++; $display("FAIL addi_rf_wren c%0d got %b exp %b", c, bus_a.regfile_wren, e_wr[c]); end
            tick();
        end
    endtask

    task automatic test_exec_u();
        bus_a.opcode = LUI;
        repeat (4) tick();
        n_cmp++; if (bus_a.regfile_wren !== 1'b1) begin n_fail++; $display("FAIL lui_wren got %b exp 1", bus_a.regfile_wren); end
        n_cmp++; if (bus_a.regfile_sel !== FROM_IMM_U) begin n_fail++; $display("FAIL lui_sel got %0d exp %0d", bus_a.regfile_sel, FROM_IMM_U); end
        n_cmp++; if (bus_a.alu_a_sel_pc !== 1'b0) begin n_fail++; $display("FAIL lui_a_pc got %b exp 0", bus_a.alu_a_sel_pc); end
        tick();
        bus_a.opcode = AUIPC;
        repeat (4) tick();
        n_cmp++; if (bus_a.regfile_wren !== 1'b1) begin n_fail++; $display("FAIL auipc_wren got %b exp 1", bus_a.regfile_wren); end
        n_cmp++; if (bus_a.regfile_sel !== FROM_ALU) begin n_fail++; $display("FAIL auipc_sel got %0d exp %0d", bus_a.regfile_sel, FROM_ALU); end
        n_cmp++; if (bus_a.alu_a_sel_pc !== 1'b1) begin n_fail++; $display("FAIL auipc_a_pc got %b exp 1", bus_a.alu_a_sel_pc); end
        tick();
    endtask

    task automatic test_branch();
        bus_a.opcode = BRANCH;
        bus_a.take_branch = 1'b1;
        repeat (4) tick();
        n_cmp++; if (bus_a.pc_inc !== 1'b1) begin n_fail++; $display("FAIL br_taken_pc_inc got %b exp 1", bus_a.pc_inc); end
        n_cmp++; if (bus_a.jumping !== BRANCH_B_TYPE) begin n_fail++; $display("FAIL br_taken_jump got %0d exp %0d", bus_a.jumping, BRANCH_B_TYPE); end
        n_cmp++; if (bus_a.regfile_wren !== 1'b0) begin n_fail++; $display("FAIL br_wren got %b exp 0", bus_a.regfile_wren); end
        tick();
        n_cmp++; if (bus_a.mem_req !== 1'b1) begin n_fail++; $display("FAIL br_next_fetch got %b exp 1", bus_a.mem_req); end
        bus_a.take_branch = 1'b0;
        repeat (4) tick();
        n_cmp++; if (bus_a.pc_inc !== 1'b0) begin n_fail++; $display("FAIL br_nt_pc_inc got %b exp 0", bus_a.pc_inc); end
        n_cmp++; if (bus_a.jumping !== NOT_JUMPING) begin n_fail++; $display("FAIL br_nt_jump got %0d exp %0d", bus_a.jumping, NOT_JUMPING); end
        tick();
        n_cmp++; if (bus_a.mem_req !== 1'b1) begin n_fail++; $display("FAIL br_nt_next_fetch got %b exp 1", bus_a.mem_req); end
    endtask

    task automatic test_jumps();
        bus_a.opcode = JAL;
        repeat (4) tick();
        n_cmp++; if (bus_a.jumping !== JUMP_J_TYPE) begin n_fail++; $display("FAIL jal_jump got %0d exp %0d", bus_a.jumping, JUMP_J_TYPE); end
        n_cmp++; if (bus_a.regfile_sel !== FROM_PC_PLUS_4) begin n_fail++; $display("FAIL jal_sel got %0d exp %0d", bus_a.regfile_sel, FROM_PC_PLUS_4); end
        n_cmp++; if ({bus_a.regfile_wren, bus_a.pc_inc} !== 2'b11) begin n_fail++; $display("FAIL jal_wren_pc got %b%b exp 11", bus_a.regfile_wren, bus_a.pc_inc); end
        tick();
        bus_a.opcode = JALR;
        repeat (4) tick();
        n_cmp++; if (bus_a.jumping !== JUMP_I_TYPE) begin n_fail++; $display("FAIL jalr_jump got %0d exp %0d", bus_a.jumping, JUMP_I_TYPE); end
        n_cmp++; if ({bus_a.regfile_wren, bus_a.pc_inc} !== 2'b11) begin n_fail++; $display("FAIL jalr_wren_pc got %b%b exp 11", bus_a.regfile_wren, bus_a.pc_inc); end
        tick();
    endtask

    task automatic test_fence();
        bus_a.opcode = MISC_MEM;
        repeat (3) tick();
        n_cmp++; if (bus_a.mem_req !== 1'b0) begin n_fail++; $display("FAIL fence_decode_req got %b exp 0", bus_a.mem_req); end
        tick();
        n_cmp++; if (bus_a.mem_req !== 1'b1) begin n_fail++; $display("FAIL fence_refetch got %b exp 1", bus_a.mem_req); end
        n_cmp++; if (bus_a.regfile_wren !== 1'b0) begin n_fail++; $display("FAIL fence_wren got %b exp 0", bus_a.regfile_wren); end
    endtask

    task automatic test_trap_vector();
        bus_a.opcode = SYSTEM;
        bus_a.is_ebreak = 1'b1;
        repeat (4) tick();
        n_cmp++; if (bus_a.trap_valid !== 1'b1) begin n_fail++; $display("FAIL ebreak_valid got %b exp 1", bus_a.trap_valid); end
        n_cmp++; if (bus_a.trap_cause !== EBREAK) begin n_fail++; $display("FAIL ebreak_cause got %0d exp %0d", bus_a.trap_cause, EBREAK); end
        n_cmp++; if (bus_a.jumping !== TRAP_VECTOR) begin n_fail++; $display("FAIL ebreak_jump got %0d exp %0d", bus_a.jumping, TRAP_VECTOR); end
        n_cmp++; if (bus_a.pc_inc !== 1'b1) begin n_fail++; $display("FAIL ebreak_pc_inc got %b exp 1", bus_a.pc_inc); end
        tick();
        n_cmp++; if (bus_a.trap_valid !== 1'b0) begin n_fail++; $display("FAIL trap_pulse_len got %b exp 0", bus_a.trap_valid); end
        n_cmp++; if (bus_a.trap_cause !== EBREAK) begin n_fail++; $display("FAIL cause_held got %0d exp %0d", bus_a.trap_cause, EBREAK); end
        n_cmp++; if (bus_a.mem_req !== 1'b1) begin n_fail++; $display("FAIL trap_next_fetch got %b exp 1", bus_a.mem_req); end
        bus_a.is_ebreak = 1'b0;
        repeat (4) tick();
        n_cmp++; if (bus_a.trap_cause !== ECALL) begin n_fail++; $display("FAIL ecall_cause got %0d exp %0d", bus_a.trap_cause, ECALL); end
        tick();
        bus_a.opcode = rv32i_opcode_t'(7'h7F);
        repeat (4) tick();
        n_cmp++; if (bus_a.trap_cause !== ILLEGAL) begin n_fail++; $display("FAIL illegal_cause got %0d exp %0d", bus_a.trap_cause, ILLEGAL); end
        n_cmp++; if (bus_a.halted !== 1'b0) begin n_fail++; $display("FAIL vector_no_halt got %b exp 0", bus_a.halted); end
        tick();
    endtask

    task automatic test_store_reset();
        bus_a.opcode = STORE;
        repeat (4) tick();
        n_cmp++; if ({bus_a.mem_req, bus_a.mem_wren, bus_a.addr_sel_alu} !== 3'b111) begin n_fail++; $display("FAIL store_mem got %b%b%b exp 111", bus_a.mem_req, bus_a.mem_wren, bus_a.addr_sel_alu); end
        n_cmp++; if (bus_a.regfile_wren !== 1'b0) begin n_fail++; $display("FAIL store_wren got %b exp 0", bus_a.regfile_wren); end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus_a.mem_req, bus_a.mem_wren} !== 2'b00) begin n_fail++; $display("FAIL store_rst_drop got %b%b exp 00", bus_a.mem_req, bus_a.mem_wren); end
        tick();
        rst_n = 1'b1;
        n_cmp++; if (bus_a.mem_req !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got %b exp 0", bus_a.mem_req); end
        tick();
        n_cmp++; if ({bus_a.mem_req, bus_a.addr_sel_alu} !== 2'b10) begin n_fail++; $display("FAIL post_rst_fetch got %b%b exp 10", bus_a.mem_req, bus_a.addr_sel_alu); end
    endtask

    task automatic test_bus_timeout();
        bus_b.opcode = OP;
        bus_b.mem_ready = 1'b0;
        do_reset();
        tick();
        repeat (5) tick();
        n_cmp++; if ({bus_b.mem_req, bus_b.trap_valid} !== 2'b10) begin n_fail++; $display("FAIL to_wait5 got %b%b exp 10", bus_b.mem_req, bus_b.trap_valid); end
        tick();
        n_cmp++; if (bus_b.trap_valid !== 1'b1) begin n_fail++; $display("FAIL to_valid got %b exp 1", bus_b.trap_valid); end
        n_cmp++; if (bus_b.trap_cause !== BUS_TIMEOUT) begin n_fail++; $display("FAIL to_cause got %0d exp %0d", bus_b.trap_cause, BUS_TIMEOUT); end
        n_cmp++; if (bus_b.jumping !== TRAP_VECTOR) begin n_fail++; $display("FAIL to_jump got %0d exp %0d", bus_b.jumping, TRAP_VECTOR); end
        tick();
        n_cmp++; if ({bus_b.mem_req, bus_b.trap_valid} !== 2'b10) begin n_fail++; $display("FAIL to_refetch got %b%b exp 10", bus_b.mem_req, bus_b.trap_valid); end
    endtask

    task automatic test_done_beats_timeout();
        repeat (5) tick();
        bus_b.mem_ready = 1'b1;
        #1;
        n_cmp++; if (bus_b.ir_wren !== 1'b1) begin n_fail++; $display("FAIL race_ir_wren got %b exp 1", bus_b.ir_wren); end
        tick();
        bus_b.mem_ready = 1'b0;
        n_cmp++; if ({bus_b.trap_valid, bus_b.mem_req} !== 2'b00) begin n_fail++; $display("FAIL race_decode got %b%b exp 00", bus_b.trap_valid, bus_b.mem_req); end
        tick();
        n_cmp++; if (bus_b.regfile_wren !== 1'b1) begin n_fail++; $display("FAIL race_exec_r got %b exp 1", bus_b.regfile_wren); end
        tick();
    endtask

    task automatic test_load_handshake();
        int req_cycles;
        req_cycles = 0;
        bus_b.opcode = LOAD;
        bus_b.mem_ready = 1'b1;
        tick();
        bus_b.mem_ready = 1'b0;
        n_cmp++; if (bus_b.mem_req !== 1'b0) begin n_fail++; $display("FAIL ld_decode_req got %b exp 0", bus_b.mem_req); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                bus_b.mem_ready = 1'b1;
                #1;
            end
            if (bus_b.mem_req === 1'b1) req_cycles++;
            n_cmp++; if (bus_b.regfile_wren !== (c == 3)) begin n_fail++; $display("FAIL ld_wren c%0d got %b exp %b", c, bus_b.regfile_wren, (c == 3)); end
            n_cmp++; if (bus_b.regfile_sel !== FROM_MEM) begin n_fail++; $display("FAIL ld_sel c%0d got %0d exp %0d", c, bus_b.regfile_sel, FROM_MEM); end
            n_cmp++; if ({bus_b.addr_sel_alu, bus_b.mem_wren} !== 2'b10) begin n_fail++; $display("FAIL ld_addr c%0d got %b%b exp 10", c, bus_b.addr_sel_alu, bus_b.mem_wren); end
        end
        n_cmp++; if (req_cycles !== 3) begin n_fail++; $display("FAIL ld_req_cycles got %0d exp 3", req_cycles); end
        tick();
        bus_b.mem_ready = 1'b0;
        n_cmp++; if ({bus_b.regfile_wren, bus_b.addr_sel_alu} !== 2'b00) begin n_fail++; $display("FAIL ld_back_fetch got %b%b exp 00", bus_b.regfile_wren, bus_b.addr_sel_alu); end
    endtask

    task automatic test_load_timeout();
        bus_b.opcode = SYSTEM;
        bus_b.is_ebreak = 1'b0;
        bus_b.mem_ready = 1'b1;
        repeat (2) tick();
        n_cmp++; if (bus_b.trap_cause !== ECALL) begin n_fail++; $display("FAIL b_ecall_cause got %0d exp %0d", bus_b.trap_cause, ECALL); end
        tick();
        bus_b.opcode = LOAD;
        tick();
        bus_b.mem_ready = 1'b0;
        tick();
        repeat (5) tick();
        n_cmp++; if ({bus_b.mem_req, bus_b.regfile_wren} !== 2'b10) begin n_fail++; $display("FAIL ldto_no_write got %b%b exp 10", bus_b.mem_req, bus_b.regfile_wren); end
        tick();
        n_cmp++; if (bus_b.trap_cause !== BUS_TIMEOUT) begin n_fail++; $display("FAIL ldto_cause got %0d exp %0d", bus_b.trap_cause, BUS_TIMEOUT); end
        n_cmp++; if (bus_b.trap_valid !== 1'b1) begin n_fail++; $display("FAIL ldto_valid got %b exp 1", bus_b.trap_valid); end
    endtask

    task automatic test_halt();
        bus_c.opcode = SYSTEM;
        bus_c.is_ebreak = 1'b0;
        bus_c.mem_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        n_cmp++; if (bus_c.trap_cause !== ECALL) begin n_fail++; $display("FAIL c_ecall_cause got %0d exp %0d", bus_c.trap_cause, ECALL); end
        bus_c.opcode = rv32i_opcode_t'(7'h7F);
        do_reset();
        n_cmp++; if (bus_c.trap_cause !== ILLEGAL) begin n_fail++; $display("FAIL c_rst_cause got %0d exp %0d", bus_c.trap_cause, ILLEGAL); end
        tick();
        n_cmp++; if (bus_c.ir_wren !== 1'b1) begin n_fail++; $display("FAIL c_fetch_ir got %b exp 1", bus_c.ir_wren); end
        repeat (2) tick();
        n_cmp++; if (bus_c.trap_valid !== 1'b1) begin n_fail++; $display("FAIL halt_trap_valid got %b exp 1", bus_c.trap_valid); end
        n_cmp++; if (bus_c.trap_cause !== ILLEGAL) begin n_fail++; $display("FAIL halt_cause got %0d exp %0d", bus_c.trap_cause, ILLEGAL); end
        n_cmp++; if ({bus_c.pc_inc, bus_c.halted} !== 2'b00) begin n_fail++; $display("FAIL halt_trap_pc got %b%b exp 00", bus_c.pc_inc, bus_c.halted); end
        n_cmp++; if (bus_c.jumping !== NOT_JUMPING) begin n_fail++; $display("FAIL halt_trap_jump got %0d exp %0d", bus_c.jumping, NOT_JUMPING); end
        for (int i = 0; i < 100; i++) begin
            tick();
            bus_c.opcode = (i % 2 == 0) ? OP : JAL;
            bus_c.mem_ready = i[0];
            bus_c.take_branch = i[1];
            n_cmp++; if ({bus_c.halted, bus_c.mem_req, bus_c.trap_valid} !== 3'b100) begin n_fail++; $display("FAIL halt_hold i%0d got %b%b%b exp 100", i, bus_c.halted, bus_c.mem_req, bus_c.trap_valid); end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_c.halted !== 1'b0) begin n_fail++; $display("FAIL halt_rst_clear got %b exp 0", bus_c.halted); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus_a.opcode = OP;  bus_a.is_ebreak = 1'b0; bus_a.take_branch = 1'b0; bus_a.mem_ready = 1'b0;
        bus_b.opcode = OP;  bus_b.is_ebreak = 1'b0; bus_b.take_branch = 1'b0; bus_b.mem_ready = 1'b0;
        bus_c.opcode = OP;  bus_c.is_ebreak = 1'b0; bus_c.take_branch = 1'b0; bus_c.mem_ready = 1'b0;
        test_reset();
        test_addi_latency();
        test_exec_u();
        test_branch();
        test_jumps();
        test_fence();
        test_trap_vector();
        test_store_reset();
        test_bus_timeout();
        test_done_beats_timeout();
        test_load_handshake();
        test_load_timeout();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
